// File: rtl/dense_layer.sv
// dense_layer: fully connected layer for the 1D-CNN classifier head.
// Takes one parallel vector of NUM_INPUTS pooled features, computes
// NUM_OUTPUTS signed fixed-point dot products (plus bias) on a single
// time-multiplexed MAC, and presents all results in parallel.
//
// Ports:
//   clk             - single clock, rising-edge
//   rst             - asynchronous active-high reset
//   dense_ready_in  - high while idle and able to accept a vector
//   dense_valid_in  - per-lane valid; a vector is accepted only when all are 1
//   dense_data_in   - input features (signed, FRAC_BITS fractional bits)
//   dense_weights   - weight (o,i) at index o*NUM_INPUTS+i, static while busy
//   dense_bias      - per-neuron bias in the same Q format
//   dense_ready_out - downstream ready
//   dense_valid_out - per-lane valid, all bits always equal
//   dense_data_out  - results (registered)
module dense_layer #(
  parameter int DATA_WIDTH  = 12,
  parameter int FRAC_BITS   = 8,
  parameter int NUM_INPUTS  = 32,
  parameter int NUM_OUTPUTS = 8,
  parameter int RELU        = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         dense_ready_in,
  input  logic [NUM_INPUTS-1:0]        dense_valid_in,
  input  logic signed [DATA_WIDTH-1:0] dense_data_in [0:NUM_INPUTS-1],
  input  logic signed [DATA_WIDTH-1:0] dense_weights [0:NUM_OUTPUTS*NUM_INPUTS-1],
  input  logic signed [DATA_WIDTH-1:0] dense_bias [0:NUM_OUTPUTS-1],
  input  logic                         dense_ready_out,
  output logic [NUM_OUTPUTS-1:0]       dense_valid_out,
  output logic signed [DATA_WIDTH-1:0] dense_data_out [0:NUM_OUTPUTS-1]
);

  localparam int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(NUM_INPUTS) + 1;
  localparam int PROD_WIDTH = 2*DATA_WIDTH;
  localparam int IW  = (NUM_INPUTS  > 1) ? $clog2(NUM_INPUTS)  : 1;
  localparam int OW  = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam int WIW = (NUM_OUTPUTS*NUM_INPUTS > 1) ? $clog2(NUM_OUTPUTS*NUM_INPUTS) : 1;

  localparam logic [IW-1:0] LAST_I = IW'(NUM_INPUTS-1);
  localparam logic [OW-1:0] LAST_O = OW'(NUM_OUTPUTS-1);

  // Saturation bounds of the output format, sign-extended to accumulator width
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                         state_r;
  logic [IW-1:0]                  i_r;
  logic [OW-1:0]                  o_r;
  logic signed [ACC_WIDTH-1:0]    acc_r;
  logic signed [DATA_WIDTH-1:0]   x_r [0:NUM_INPUTS-1];

  logic [WIW-1:0]                 w_idx_s;
  logic signed [PROD_WIDTH-1:0]   prod_s;
  logic signed [ACC_WIDTH-1:0]    bias_ext_s;
  logic signed [ACC_WIDTH-1:0]    base_s;
  logic signed [ACC_WIDTH-1:0]    acc_next_s;
  logic signed [ACC_WIDTH-1:0]    shifted_s;
  logic signed [DATA_WIDTH-1:0]   sat_s;
  logic signed [DATA_WIDTH-1:0]   post_s;

  // MAC datapath: next accumulator value and its post-processed output form
  always_comb begin
    w_idx_s    = WIW'(o_r) * WIW'(NUM_INPUTS) + WIW'(i_r);
    prod_s     = x_r[i_r] * dense_weights[w_idx_s];
    bias_ext_s = {{(ACC_WIDTH-DATA_WIDTH){dense_bias[o_r][DATA_WIDTH-1]}}, dense_bias[o_r]};
    // First product of a neuron starts from the bias aligned to the product's Q format
    if (i_r == '0) begin
      base_s = bias_ext_s <<< FRAC_BITS;
    end else begin
      base_s = acc_r;
    end
    acc_next_s = base_s + {{(ACC_WIDTH-PROD_WIDTH){prod_s[PROD_WIDTH-1]}}, prod_s};
    // Arithmetic shift floors toward minus infinity
    shifted_s  = acc_next_s >>> FRAC_BITS;
    if (shifted_s > SAT_MAX) begin
      sat_s = SAT_MAX[DATA_WIDTH-1:0];
    end else if (shifted_s < SAT_MIN) begin
      sat_s = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      sat_s = shifted_s[DATA_WIDTH-1:0];
    end
    if ((RELU == 1) && sat_s[DATA_WIDTH-1]) begin
      post_s = '0;
    end else begin
      post_s = sat_s;
    end
  end

  // Control FSM, counters, accumulator, input capture and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      i_r             <= '0;
      o_r             <= '0;
      acc_r           <= '0;
      dense_ready_in  <= 1'b1;
      dense_valid_out <= '0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
        x_r[k] <= '0;
      end
      for (int k = 0; k < NUM_OUTPUTS; k++) begin
        dense_data_out[k] <= '0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          // Partial valid is ignored; only a complete vector is captured
          if (&dense_valid_in) begin
            for (int k = 0; k < NUM_INPUTS; k++) begin
              x_r[k] <= dense_data_in[k];
            end
            i_r            <= '0;
            o_r            <= '0;
            dense_ready_in <= 1'b0;
            state_r        <= MAC;
          end else begin
            state_r <= IDLE;
          end
        end
        MAC: begin
          acc_r <= acc_next_s;
          if (i_r == LAST_I) begin
            dense_data_out[o_r] <= post_s;
            i_r                 <= '0;
            if (o_r == LAST_O) begin
              o_r             <= '0;
              dense_valid_out <= '1;
              state_r         <= DONE;
            end else begin
              o_r <= o_r + 1'b1;
            end
          end else begin
            i_r <= i_r + 1'b1;
          end
        end
        DONE: begin
          if (dense_ready_out) begin
            dense_valid_out <= '0;
            dense_ready_in  <= 1'b1;
            state_r         <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r         <= IDLE;
          i_r             <= '0;
          o_r             <= '0;
          dense_valid_out <= '0;
          dense_ready_in  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/dense_layer.md
# dense_layer

Fully connected layer for the 1D-CNN classifier head. It sits directly downstream of the global average pool layer and consumes one parallel vector of NUM_INPUTS pooled features. It computes NUM_OUTPUTS signed fixed-point dot products with a single time-multiplexed multiply-accumulate unit, then presents all results in parallel on an AXI-style valid/ready output.

## Interface
- DATA_WIDTH, 12, width of input features, weights, biases and outputs (signed two's complement)
- FRAC_BITS, 8, fractional bits of the shared Q format
- NUM_INPUTS, 32, input vector length (one per upstream pool)
- NUM_OUTPUTS, 8, number of neurons / output lanes
- RELU, 0, 1 = clamp negative results to 0 after saturation
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset; asynchronous and active-high
- dense_ready_in  output  1  high only in IDLE
- dense_valid_in  input  NUM_INPUTS  per-lane valid from upstream
- dense_data_in  input  DATA_WIDTH x [0:NUM_INPUTS-1]  input features
- dense_weights  input  DATA_WIDTH x [0:NUM_OUTPUTS*NUM_INPUTS-1]  weight for (o,i) at index o*NUM_INPUTS+i; static during operation
- dense_bias  input  DATA_WIDTH x [0:NUM_OUTPUTS-1]  per-neuron bias, same Q format
- dense_ready_out  input  1  downstream ready
- dense_valid_out  output  NUM_OUTPUTS  per-lane valid; all bits always equal
- dense_data_out  output  DATA_WIDTH x [0:NUM_OUTPUTS-1]  results

## Operation
- FSM states: IDLE, MAC, DONE.
- IDLE: dense_ready_in=1. Accept when every bit of dense_valid_in is 1 at a rising edge. Capture all inputs into the input register, clear counters o=0 and i=0, then go to MAC. Partial valid (any bit 0) is ignored and causes no capture.
- MAC, one product per cycle: acc_next = (i==0 ? bias[o]<<<FRAC_BITS : acc) + x[i]*w[o*NUM_INPUTS+i]; acc <= acc_next; i increments.
- When i==NUM_INPUTS-1: out_reg[o] <= post(acc_next); i<=0; o increments. After o==NUM_OUTPUTS-1 completes, go to DONE.
- DONE: dense_valid_out all 1s and dense_data_out = out_reg. Both are held stable until dense_ready_out=1 at an edge, then go to IDLE with valid_out cleared. out_reg keeps its values but is not qualified by valid.
- Arithmetic widths:
  - product is 2*DATA_WIDTH signed
  - accumulator ACC_WIDTH = 2*DATA_WIDTH + clog2(NUM_INPUTS) + 1 signed; it never overflows
  - bias is sign-extended, then shifted left by FRAC_BITS
- post(): arithmetic shift right by FRAC_BITS (floor). Then saturate to [-(2^(DATA_WIDTH-1)), 2^(DATA_WIDTH-1)-1]. Then apply ReLU if RELU=1.
- No overlap: a new vector is accepted only after DONE has been consumed.
- Reset (any time, including mid-MAC or in DONE): state=IDLE, counters=0, acc=0, out_reg=0, input register=0. dense_valid_out=0 and dense_data_out=0 immediately (asynchronous). dense_ready_in=1 while reset is held and after it releases.

## Timing
- Reset values: dense_ready_in=1, dense_valid_out=0, dense_data_out all 0.
- Accept edge E. MAC occupies the NUM_OUTPUTS*NUM_INPUTS cycles after E. dense_valid_out rises at edge E+NUM_OUTPUTS*NUM_INPUTS.
- Default parameters: 256 cycles of latency.
- dense_ready_in falls at edge E and rises again at the edge where the DONE handshake completes. The earliest next accept is the edge after that.
- If dense_ready_out is already high when DONE is entered, valid is high for exactly one cycle.
- Throughput: one vector per NUM_OUTPUTS*NUM_INPUTS+2 cycles minimum.
- Outputs are registered only; there is no combinational path from any input to any output.

## Test plan
Test parameters unless stated otherwise: NUM_INPUTS=4, NUM_OUTPUTS=2, FRAC_BITS=8, DATA_WIDTH=12.

1. Basic result: all x=256 (1.0), all w=128 (0.5), bias=0.
   - Both outputs = 512.
   - valid_out rises exactly 8 edges after accept.
   - ready_in is low throughout.
2. Bias and floor rounding: x={1,0,0,0}, w[0]=1, bias[0]=256, bias[1]=-1.
   - out0 = 256 (1/256 is floored away).
   - out1 = -1.
3. Saturation and ReLU: x=2047, w=2047, bias=2047.
   - Both outputs saturate to 2047.
   - With w=-2047: outputs = -2048 when RELU=0, and 0 when RELU=1.
4. Backpressure and partial valid:
   - Hold ready_out=0 for 10 cycles in DONE: data and valid stay stable and ready_in stays 0.
   - Raise ready_out: valid clears at the next edge and ready_in=1.
   - valid_in=4'b0111 held for 5 cycles: no accept.
5. Reset mid-operation: assert rst during cycle 3 of MAC.
   - valid_out=0, data_out=0 and ready_in=1 immediately.
   - A following vector from scenario 1 produces 512 on both outputs.
6. Back-to-back: two vectors with ready_out tied high.
   - Each result is correct.
   - The second accept occurs no earlier than 10 edges after the first.
